// File: rtl/ysyx_22050039_lsu_if.sv
// Bundle of the upstream record, data-memory port and write-back record
// around the load/store unit. The master side is the LSU itself; the
// slave side is the surrounding pipeline and memory system.
interface ysyx_22050039_lsu_if #(
    parameter int XLEN = 64
);
    // upstream (execute -> LSU)
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_mem_op;
    logic [1:0]      in_size;
    logic            in_unsigned;
    logic [XLEN-1:0] in_result;
    logic [XLEN-1:0] in_wdata;
    logic [4:0]      in_rd;
    logic            in_rf_wen;

    // data-memory request/response
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wen;
    logic [63:0]     mem_wdata;
    logic [7:0]      mem_wmask;
    logic            mem_resp_valid;
    logic [63:0]     mem_rdata;

    // write-back record (LSU -> next stage)
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_rf_wen;
    logic            out_misalign;

    modport master (
        input  in_valid, in_mem_op, in_size, in_unsigned, in_result,
               in_wdata, in_rd, in_rf_wen,
        output in_ready,
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output out_valid, out_result, out_rd, out_rf_wen, out_misalign,
        input  out_ready
    );

    modport slave (
        output in_valid, in_mem_op, in_size, in_unsigned, in_result,
               in_wdata, in_rd, in_rf_wen,
        input  in_ready,
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  out_valid, out_result, out_rd, out_rf_wen, out_misalign,
        output out_ready
    );
endinterface

// File: rtl/ysyx_22050039_lsu.sv
// Load/store stage: takes one execute record at a time, performs an aligned
// byte/half/word/double access over a 64-bit memory port (or passes the
// record straight through), and presents one write-back record.
module ysyx_22050039_lsu #(
    parameter int XLEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22050039_lsu_if.master      bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    // Byte strobes for an access of the given size starting at lane 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    // An access is misaligned when the offset is not a multiple of its size.
    function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = off[0];
            2'd2:    is_misaligned = |off[1:0];
            default: is_misaligned = |off;
        endcase
    endfunction

    // Pick the addressed lane out of the aligned doubleword, truncate and extend.
    function automatic logic [63:0] load_extend(input logic [63:0] raw,
                                                input logic [2:0]  off,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [63:0]        lane;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] w;
        lane = raw >> {off, 3'b000};
        b    = signed'(lane[7:0]);
        h    = signed'(lane[15:0]);
        w    = signed'(lane[31:0]);
        case (size)
            2'd0:    load_extend = uns ? {56'd0, lane[7:0]}  : {{56{b[7]}},  b};
            2'd1:    load_extend = uns ? {48'd0, lane[15:0]} : {{48{h[15]}}, h};
            2'd2:    load_extend = uns ? {32'd0, lane[31:0]} : {{32{w[31]}}, w};
            default: load_extend = lane;
        endcase
    endfunction

    state_t          state_q, state_d;
    logic [2:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            unsigned_q, unsigned_d;
    logic            is_store_q, is_store_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic            mem_wen_q, mem_wen_d;
    logic [63:0]     mem_wdata_q, mem_wdata_d;
    logic [7:0]      mem_wmask_q, mem_wmask_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [4:0]      out_rd_q, out_rd_d;
    logic            out_rf_wen_q, out_rf_wen_d;
    logic            out_misalign_q, out_misalign_d;

    logic            in_is_load;
    logic            in_is_store;
    logic            in_misal;
    logic [2:0]      in_off;

    // Decode the incoming record; only meaningful while IDLE and in_valid.
    always_comb begin
        in_off      = bus.in_result[2:0];
        in_is_load  = (bus.in_mem_op == OP_LOAD);
        in_is_store = (bus.in_mem_op == OP_STORE);
        in_misal    = (in_is_load || in_is_store) && is_misaligned(in_off, bus.in_size);
    end

    // Next-state and next-record computation for the four-state handshake FSM.
    always_comb begin
        state_d        = state_q;
        off_d          = off_q;
        size_d         = size_q;
        unsigned_d     = unsigned_q;
        is_store_d     = is_store_q;
        mem_addr_d     = mem_addr_q;
        mem_wen_d      = mem_wen_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wmask_d    = mem_wmask_q;
        out_result_d   = out_result_q;
        out_rd_d       = out_rd_q;
        out_rf_wen_d   = out_rf_wen_q;
        out_misalign_d = out_misalign_q;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    off_d          = in_off;
                    size_d         = bus.in_size;
                    unsigned_d     = bus.in_unsigned;
                    is_store_d     = in_is_store;
                    out_rd_d       = bus.in_rd;
                    out_misalign_d = in_misal;
                    out_rf_wen_d   = bus.in_rf_wen && (bus.in_rd != 5'd0)
                                     && !in_is_store && !in_misal;
                    if ((!in_is_load && !in_is_store) || in_misal) begin
                        // pass-through value, or the faulting address
                        out_result_d = bus.in_result;
                        state_d      = S_DONE;
                    end else begin
                        mem_addr_d  = {bus.in_result[XLEN-1:3], 3'b000};
                        mem_wen_d   = in_is_store;
                        mem_wdata_d = bus.in_wdata << {in_off, 3'b000};
                        mem_wmask_d = size_mask(bus.in_size) << in_off;
                        state_d     = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_resp_valid) begin
                    out_result_d = is_store_q ? '0
                                 : load_extend(bus.mem_rdata, off_q, size_q, unsigned_q);
                    state_d      = S_DONE;
                end
            end
            default: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State and record registers; reset drops any in-flight record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            off_q          <= '0;
            size_q         <= '0;
            unsigned_q     <= 1'b0;
            is_store_q     <= 1'b0;
            mem_addr_q     <= '0;
            mem_wen_q      <= 1'b0;
            mem_wdata_q    <= '0;
            mem_wmask_q    <= '0;
            out_result_q   <= '0;
            out_rd_q       <= '0;
            out_rf_wen_q   <= 1'b0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            off_q          <= off_d;
            size_q         <= size_d;
            unsigned_q     <= unsigned_d;
            is_store_q     <= is_store_d;
            mem_addr_q     <= mem_addr_d;
            mem_wen_q      <= mem_wen_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wmask_q    <= mem_wmask_d;
            out_result_q   <= out_result_d;
            out_rd_q       <= out_rd_d;
            out_rf_wen_q   <= out_rf_wen_d;
            out_misalign_q <= out_misalign_d;
        end
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        bus.in_ready      = (state_q == S_IDLE);
        bus.mem_req_valid = (state_q == S_REQ);
        bus.out_valid     = (state_q == S_DONE);
        bus.mem_addr      = mem_addr_q;
        bus.mem_wen       = mem_wen_q;
        bus.mem_wdata     = mem_wdata_q;
        bus.mem_wmask     = mem_wmask_q;
        bus.out_result    = out_result_q;
        bus.out_rd        = out_rd_q;
        bus.out_rf_wen    = out_rf_wen_q;
        bus.out_misalign  = out_misalign_q;
    end

endmodule

// File: tb/tb_ysyx_22050039_lsu.sv
// Directed bench for the load/store stage: pass-through, loads of every size
// and signedness, stores, misalignment, stalls on both handshakes and reset.
module tb_ysyx_22050039_lsu;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    ysyx_22050039_lsu_if #(.XLEN(64)) bus ();

    ysyx_22050039_lsu #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one record for exactly one cycle; the LSU must be IDLE.
    task automatic accept(input logic [1:0] op, input logic [1:0] size, input logic uns,
                          input logic [63:0] result, input logic [63:0] wdata,
                          input logic [4:0] rd, input logic rf_wen);
        bus.in_valid    = 1'b1;
        bus.in_mem_op   = op;
        bus.in_size     = size;
        bus.in_unsigned = uns;
        bus.in_result   = result;
        bus.in_wdata    = wdata;
        bus.in_rd       = rd;
        bus.in_rf_wen   = rf_wen;
        step();
        bus.in_valid    = 1'b0;
        bus.in_mem_op   = 2'd0;
        bus.in_result   = 64'd0;
        bus.in_wdata    = 64'd0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"},      bus.in_ready,      64'd1);
        chk({tag, "_mem_req_valid"}, bus.mem_req_valid, 64'd0);
        chk({tag, "_mem_wen"},       bus.mem_wen,       64'd0);
        chk({tag, "_mem_addr"},      bus.mem_addr,      64'd0);
        chk({tag, "_mem_wdata"},     bus.mem_wdata,     64'd0);
        chk({tag, "_mem_wmask"},     bus.mem_wmask,     64'd0);
        chk({tag, "_out_valid"},     bus.out_valid,     64'd0);
        chk({tag, "_out_result"},    bus.out_result,    64'd0);
        chk({tag, "_out_rd"},        bus.out_rd,        64'd0);
        chk({tag, "_out_rf_wen"},    bus.out_rf_wen,    64'd0);
        chk({tag, "_out_misalign"},  bus.out_misalign,  64'd0);
    endtask

    // Zero-wait load: accept at T, handshake T+1, response T+2, record from T+3.
    task automatic run_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input logic uns, input logic [63:0] rdata, input logic [4:0] rd,
                            input logic [63:0] exp_addr, input logic [63:0] exp_res,
                            input logic exp_wen);
        accept(2'd1, size, uns, addr, 64'd0, rd, 1'b1);
        chk({tag, "_req_valid"}, bus.mem_req_valid, 64'd1);
        chk({tag, "_mem_addr"},  bus.mem_addr,      exp_addr);
        chk({tag, "_mem_wen"},   bus.mem_wen,       64'd0);
        chk({tag, "_early_out"}, bus.out_valid,     64'd0);
        step();
        chk({tag, "_wait"},      bus.mem_req_valid, 64'd0);
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rdata;
        step();
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 64'd0;
        chk({tag, "_out_valid"}, bus.out_valid,  64'd1);
        chk({tag, "_result"},    bus.out_result, exp_res);
        chk({tag, "_rd"},        bus.out_rd,     {59'd0, rd});
        chk({tag, "_rf_wen"},    bus.out_rf_wen, {63'd0, exp_wen});
        chk({tag, "_misalign"},  bus.out_misalign, 64'd0);
        step();
        chk({tag, "_drained"},   bus.out_valid, 64'd0);
        chk({tag, "_in_ready"},  bus.in_ready,  64'd1);
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        rst                = 1'b1;
        bus.in_valid       = 1'b0;
        bus.in_mem_op      = 2'd0;
        bus.in_size        = 2'd0;
        bus.in_unsigned    = 1'b0;
        bus.in_result      = 64'd0;
        bus.in_wdata       = 64'd0;
        bus.in_rd          = 5'd0;
        bus.in_rf_wen      = 1'b0;
        bus.mem_req_ready  = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata      = 64'd0;
        bus.out_ready      = 1'b1;
        step();
        step();
        chk_reset_state("reset");
        rst = 1'b0;
        step();

        // pass-through record, one cycle latency
        accept(2'd0, 2'd0, 1'b0, 64'h1234, 64'd0, 5'd5, 1'b1);
        chk("pt_out_valid", bus.out_valid,     64'd1);
        chk("pt_result",    bus.out_result,    64'h1234);
        chk("pt_rd",        bus.out_rd,        64'd5);
        chk("pt_rf_wen",    bus.out_rf_wen,    64'd1);
        chk("pt_misalign",  bus.out_misalign,  64'd0);
        chk("pt_no_req",    bus.mem_req_valid, 64'd0);
        chk("pt_in_ready",  bus.in_ready,      64'd0);
        step();
        chk("pt_drained",   bus.out_valid,     64'd0);

        // reserved op behaves as pass-through
        accept(2'd3, 2'd3, 1'b0, 64'hDEAD_0001, 64'd0, 5'd6, 1'b1);
        chk("rsv_no_req",   bus.mem_req_valid, 64'd0);
        chk("rsv_result",   bus.out_result,    64'hDEAD_0001);
        step();

        // loads across sizes and signedness
        run_load("lb_s", 64'h8000_0003, 2'd0, 1'b0, 64'h0000_0000_8000_0000, 5'd7,
                 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 1'b1);
        run_load("lb_u", 64'h8000_0003, 2'd0, 1'b1, 64'h0000_0000_8000_0000, 5'd7,
                 64'h8000_0000, 64'h0000_0000_0000_0080, 1'b1);
        run_load("ld_rd0", 64'h2008, 2'd3, 1'b0, 64'h0123_4567_89AB_CDEF, 5'd0,
                 64'h2008, 64'h0123_4567_89AB_CDEF, 1'b0);
        run_load("lw_s", 64'h2004, 2'd2, 1'b0, 64'h8765_4321_0000_0000, 5'd10,
                 64'h2000, 64'hFFFF_FFFF_8765_4321, 1'b1);
        run_load("lh_u", 64'h2006, 2'd1, 1'b1, 64'hA5B6_0000_0000_0000, 5'd11,
                 64'h2000, 64'h0000_0000_0000_A5B6, 1'b1);
        run_load("lh_s", 64'h2002, 2'd1, 1'b0, 64'h0000_0000_8001_0000, 5'd12,
                 64'h2000, 64'hFFFF_FFFF_FFFF_8001, 1'b1);

        // half store at offset 6
        accept(2'd2, 2'd1, 1'b0, 64'h1006, 64'hBEEF, 5'd3, 1'b1);
        chk("sh_req_valid", bus.mem_req_valid,  64'd1);
        chk("sh_mem_addr",  bus.mem_addr,       64'h1000);
        chk("sh_mem_wen",   bus.mem_wen,        64'd1);
        chk("sh_wmask",     bus.mem_wmask,      64'hC0);
        chk("sh_wdata_hi",  bus.mem_wdata >> 48, 64'hBEEF);
        step();
        bus.mem_resp_valid = 1'b1;
        step();
        bus.mem_resp_valid = 1'b0;
        chk("sh_out_valid", bus.out_valid,  64'd1);
        chk("sh_result",    bus.out_result, 64'd0);
        chk("sh_rf_wen",    bus.out_rf_wen, 64'd0);
        step();

        // misaligned word load never reaches memory
        accept(2'd1, 2'd2, 1'b0, 64'h1002, 64'd0, 5'd4, 1'b1);
        chk("mis_no_req",   bus.mem_req_valid, 64'd0);
        chk("mis_valid",    bus.out_valid,     64'd1);
        chk("mis_flag",     bus.out_misalign,  64'd1);
        chk("mis_result",   bus.out_result,    64'h1002);
        chk("mis_rf_wen",   bus.out_rf_wen,    64'd0);
        step();

        // misaligned double store
        accept(2'd2, 2'd3, 1'b0, 64'h3004, 64'h55, 5'd4, 1'b1);
        chk("mis_d_no_req", bus.mem_req_valid, 64'd0);
        chk("mis_d_flag",   bus.out_misalign,  64'd1);
        step();

        // request stall (3 cycles), then write-back stall (2 cycles)
        bus.mem_req_ready = 1'b0;
        accept(2'd2, 2'd2, 1'b0, 64'h3004, 64'hCAFE_F00D, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", bus.mem_req_valid, 64'd1);
            chk("stall_addr",      bus.mem_addr,      64'h3000);
            chk("stall_wmask",     bus.mem_wmask,     64'hF0);
            chk("stall_wdata",     bus.mem_wdata,     64'hCAFE_F00D_0000_0000);
            chk("stall_in_ready",  bus.in_ready,      64'd0);
            step();
        end
        bus.mem_req_ready = 1'b1;
        chk("stall_req_hs", bus.mem_req_valid, 64'd1);
        step();
        bus.mem_resp_valid = 1'b1;
        step();
        bus.mem_resp_valid = 1'b0;
        bus.out_ready      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp_out_valid", bus.out_valid,  64'd1);
            chk("bp_result",    bus.out_result, 64'd0);
            chk("bp_rd",        bus.out_rd,     64'd9);
            chk("bp_in_ready",  bus.in_ready,   64'd0);
            step();
        end
        bus.out_ready = 1'b1;
        chk("bp_release", bus.out_valid, 64'd1);
        step();
        chk("bp_one_record", bus.out_valid, 64'd0);
        chk("bp_in_ready1",  bus.in_ready,  64'd1);

        // reset while waiting for the response
        accept(2'd1, 2'd3, 1'b0, 64'h4000, 64'd0, 5'd8, 1'b1);
        step();
        chk("rstmid_in_wait", bus.mem_req_valid, 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_state("rstmid");
        run_load("post_rst", 64'h4010, 2'd2, 1'b1, 64'hFFFF_FFFF_1357_9BDF, 5'd13,
                 64'h4010, 64'h0000_0000_1357_9BDF, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
